// File: rtl/data_mem_responder.sv
// Data-memory responder: word-organised RAM answering single core load/store
// requests after WAIT_STATES wait cycles. Optional range check: DM_RANGE_CHECK_EN.
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDRESS     = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  request,
  input  logic                  we_re,
  input  logic [3:0]            mask,
  input  logic [ADDRESS-1:0]    address,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  valid,
  output logic                  busy,
  output logic                  err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_reg, state_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic [IDX_W-1:0]      idx_reg;
  logic                  we_reg;
  logic [3:0]            mask_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  oor_reg;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0]      addr_idx;
  logic                  addr_oor;
  logic                  unused_addr_bits;

  assign addr_idx = address[IDX_W+1:2];

`ifdef DM_RANGE_CHECK_EN
  assign addr_oor         = |address[ADDRESS-1:IDX_W+2];
  assign unused_addr_bits = ^address[1:0];
`else
  assign addr_oor         = 1'b0;
  assign unused_addr_bits = ^{address[ADDRESS-1:IDX_W+2], address[1:0]};
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (request) begin
          if (WAIT_STATES > 0) begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) state_next = RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      idx_reg   <= '0;
      we_reg    <= 1'b0;
      mask_reg  <= 4'd0;
      data_reg  <= '0;
      oor_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == IDLE && request) begin
        idx_reg  <= addr_idx;
        we_reg   <= we_re;
        mask_reg <= mask;
        data_reg <= store_data;
        oor_reg  <= addr_oor;
      end
    end
  end

  // With zero wait states the accept edge is also the commit edge, so live inputs are used.
  logic                  in_idle, enter_resp, ram_we;
  logic [IDX_W-1:0]      cur_idx;
  logic                  cur_we, cur_oor;
  logic [3:0]            cur_mask;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [3:0]            lane_we;

  assign in_idle    = (state_reg == IDLE);
  assign cur_idx    = in_idle ? addr_idx   : idx_reg;
  assign cur_we     = in_idle ? we_re      : we_reg;
  assign cur_mask   = in_idle ? mask       : mask_reg;
  assign cur_data   = in_idle ? store_data : data_reg;
  assign cur_oor    = in_idle ? addr_oor   : oor_reg;
  assign enter_resp = (state_next == RESP);
  // Gated by rst so a pending write can never land while reset is held.
  assign ram_we     = enter_resp && cur_we && !cur_oor && rst;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = ram_we & cur_mask[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) mem[cur_idx][8*i +: 8] <= cur_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_data <= '0;
    end else if (enter_resp && !cur_we) begin
      load_data <= cur_oor ? '0 : mem[cur_idx];
    end
  end

  assign valid = (state_reg == RESP);
  assign busy  = (state_reg != IDLE);

`ifdef DM_RANGE_CHECK_EN
  assign err = valid & oor_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (slave) end of the core's data-memory request interface.
- Accepts single read or write transactions from the core's memory stage: request, we_re, 4-bit byte mask, word address and store data.
- Holds a word-organised RAM and returns load data with a one-cycle valid pulse after a programmable number of wait states.
- Sits outside the core next to the instruction memory; feeds the core's DM_load_data_in and DM_valid inputs.

Parameters:
DATA_WIDTH, 32, data word width (fixed at 32; mask is 4 bits)
ADDRESS, 32, byte address width
DEPTH_WORDS, 1024, RAM depth in 32-bit words (power of two)
WAIT_STATES, 1, extra cycles between accept and response (0..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
request  in  1  transaction request from core, held until valid
we_re  in  1  1 = write (store), 0 = read (load)
mask  in  4  byte enables for writes, bit i = byte lane i
address  in  ADDRESS  byte address; bits [1:0] ignored
store_data  in  DATA_WIDTH  write data, lane-aligned
load_data  out  DATA_WIDTH  full read word, registered
valid  out  1  one-cycle response strobe for both reads and writes
busy  out  1  high from accept until the valid cycle inclusive
err  out  1  out-of-range flag, qualified by valid (see Optional Feature)

Behaviour:
- Word index is address[log2(DEPTH_WORDS)+1:2]; upper bits are ignored unless RANGE_CHECK_EN is defined.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - request=1 is accepted on that clock edge; address, we_re, mask and store_data are captured.
  - Next state is WAIT when WAIT_STATES>0, else RESP.
- WAIT:
  - A down-counter is loaded with WAIT_STATES-1 at accept and decrements each cycle.
  - When the count reaches 0, next state is RESP.
  - Input changes during WAIT are ignored; captured values are used.
- RESP:
  - valid=1 for exactly one cycle.
  - Next state is always IDLE, even if request is still high; a new accept cannot occur before the following cycle.
  - A request held continuously therefore yields one transaction per WAIT_STATES+2 cycles.
- Latency: valid asserts WAIT_STATES+1 cycles after the accept edge. With WAIT_STATES=0, valid is high in the cycle after accept.
- Writes:
  - Committed on the edge that enters RESP.
  - Only lanes with mask[i]=1 are updated; mask=0000 is a legal no-op write and still produces valid.
- Reads:
  - load_data is loaded on the edge entering RESP and holds its value until the next read response.
  - mask is ignored on reads; byte/half extraction and sign extension stay in the core.
- Read during write to the same word cannot occur (single outstanding transaction).
- busy=1 whenever state != IDLE.
- Reset, asserted asynchronously in any state:
  - state=IDLE, counter=0, valid=0, load_data=0, busy=0, err=0.
  - Captured transaction is discarded; a write not yet committed is never committed.
  - RAM contents are not reset.

Optional Feature:
- Macro: DM_RANGE_CHECK_EN.
- Defined:
  - If any address bit above the word-index range is nonzero, the transaction is out of range.
  - It completes with normal timing, but a write updates no RAM and a read returns 32'h0000_0000.
  - err=1 in the valid cycle; err is 0 in all other cycles.
- Undefined: upper address bits alias into the RAM and err is tied to 0.

Test Plan:
- Reset, then read: rst low mid-WAIT of a write to 0x10 with data 0xDEADBEEF → no valid, busy=0; a later read of 0x10 returns the prior contents.
- Word write/read, WAIT_STATES=1:
  - Write 0x0000_0040 with 0x1234_5678, mask 1111 → valid 2 cycles after accept.
  - Read 0x40 → load_data=0x1234_5678, valid 2 cycles after accept.
- Byte mask: over 0x1234_5678 at 0x40, write 0xAABB_CCDD with mask 0101 → read returns 0x12BB_56DD; mask 0000 → valid pulses, contents unchanged.
- Latency sweep WAIT_STATES=0 and 3, request held high → valid period is 2 and 5 cycles respectively, one pulse per transaction, never two consecutive valid cycles.
- Address aliasing: DEPTH_WORDS=1024, read 0x0000_1040 after writing 0x40; address 0x43 maps to the same word.
  - Without the macro: returns the word at 0x40, err=0.
  - With DM_RANGE_CHECK_EN: returns 0, err=1 in the valid cycle.
- Input hold: change address/store_data during WAIT → the captured values are used; load_data holds its value across subsequent write responses.
